// File: rtl/rob_mp_if.sv
// Issue / writeback / query / retire bundle of the reorder buffer.
// The ROB takes the slave side; the surrounding pipeline drives the master side.
interface rob_mp_if #(
    parameter int ROB_BIT  = 3,
    parameter int WB_PORTS = 4,
    parameter int REG_BIT  = 5
);
    logic                        issue_valid;
    logic                        issue_ready;
    logic [1:0]                  issue_kind;
    logic [REG_BIT-1:0]          issue_rd;
    logic                        issue_done;
    logic [31:0]                 issue_value;
    logic                        issue_pred_taken;
    logic [ROB_BIT-1:0]          issue_entry;
    logic [WB_PORTS-1:0]         wb_valid;
    logic [WB_PORTS*ROB_BIT-1:0] wb_entry;
    logic [WB_PORTS*32-1:0]      wb_value;
    logic [WB_PORTS-1:0]         wb_taken;
    logic [WB_PORTS*32-1:0]      wb_target;
    logic [ROB_BIT-1:0]          qry_entry;
    logic                        qry_ready;
    logic [31:0]                 qry_value;
    logic                        commit_valid;
    logic [REG_BIT-1:0]          commit_rd;
    logic [31:0]                 commit_value;
    logic [ROB_BIT-1:0]          commit_entry;
    logic                        store_commit;
    logic                        store_ack;
    logic                        flush;
    logic [31:0]                 flush_pc;
    logic                        halt;
    logic [ROB_BIT:0]            count;
    logic                        empty;

    modport slave (
        input  issue_valid, issue_kind, issue_rd, issue_done, issue_value, issue_pred_taken,
        input  wb_valid, wb_entry, wb_value, wb_taken, wb_target,
        input  qry_entry, store_ack,
        output issue_ready, issue_entry, qry_ready, qry_value,
        output commit_valid, commit_rd, commit_value, commit_entry,
        output store_commit, flush, flush_pc, halt, count, empty
    );

    modport master (
        output issue_valid, issue_kind, issue_rd, issue_done, issue_value, issue_pred_taken,
        output wb_valid, wb_entry, wb_value, wb_taken, wb_target,
        output qry_entry, store_ack,
        input  issue_ready, issue_entry, qry_ready, qry_value,
        input  commit_valid, commit_rd, commit_value, commit_entry,
        input  store_commit, flush, flush_pc, halt, count, empty
    );
endinterface

// File: rtl/rob_mp.sv
// Reorder buffer with multi-port writeback, in-order single retire,
// store-commit handshake, mispredict flush and sticky halt.
module rob_mp #(
    parameter int ROB_BIT  = 3,
    parameter int WB_PORTS = 4,
    parameter int REG_BIT  = 5
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    rob_mp_if.slave bus
);
    localparam int DEPTH = 1 << ROB_BIT;
    localparam logic [ROB_BIT:0]   FULL    = (ROB_BIT+1)'(DEPTH);
    localparam logic [ROB_BIT:0]   CNT_ONE = (ROB_BIT+1)'(1);
    localparam logic [ROB_BIT-1:0] PTR_ONE = ROB_BIT'(1);
    localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_HALT = 2'd3;

    typedef enum logic {IDLE, ST_WAIT} state_t;

    logic [DEPTH-1:0]   busy, ready, pred, mispredict;
    logic [1:0]         kind   [DEPTH];
    logic [REG_BIT-1:0] rd     [DEPTH];
    logic [31:0]        value  [DEPTH];
    logic [31:0]        target [DEPTH];
    logic [ROB_BIT-1:0] head, tail;
    logic [ROB_BIT:0]   count;
    state_t             state, state_nx;

    logic               cm_valid, fl_pulse, halted;
    logic [REG_BIT-1:0] cm_rd;
    logic [31:0]        cm_value, fl_pc;
    logic [ROB_BIT-1:0] cm_entry;

    logic can_issue, alloc, head_ok, pop, fire_reg, fire_flush, fire_halt;
    logic [DEPTH-1:0] wb_hit, wb_tk;
    logic [31:0]      wb_val [DEPTH];
    logic [31:0]      wb_tgt [DEPTH];
    logic             qry_hit;
    logic [31:0]      qry_byp;

    assign can_issue = (count < FULL) && !halted;
    assign head_ok   = rdy_in && !halted && busy[head] && ready[head];
    assign alloc     = bus.issue_valid && can_issue && rdy_in && !fire_flush;

    // Retire decision for the head entry; store waits for the LSB ack.
    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        fire_reg   = 1'b0;
        fire_flush = 1'b0;
        fire_halt  = 1'b0;
        case (state)
            IDLE: begin
                if (head_ok) begin
                    case (kind[head])
                        K_REG:    begin pop = 1'b1; fire_reg = 1'b1; end
                        K_BRANCH: begin
                            if (mispredict[head]) fire_flush = 1'b1;
                            else                  pop = 1'b1;
                        end
                        K_STORE:  state_nx = ST_WAIT;
                        default:  fire_halt = 1'b1;
                    endcase
                end
            end
            ST_WAIT: begin
                if (rdy_in && bus.store_ack) begin
                    pop      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Fold the writeback ports onto entries; a higher port overrides a lower one.
    always_comb begin
        wb_hit = '0;
        wb_tk  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_val[i] = '0;
            wb_tgt[i] = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_valid[p] && bus.wb_entry[p*ROB_BIT +: ROB_BIT] == ROB_BIT'(i)) begin
                    wb_hit[i] = 1'b1;
                    wb_val[i] = bus.wb_value[p*32 +: 32];
                    wb_tk[i]  = bus.wb_taken[p];
                    wb_tgt[i] = bus.wb_target[p*32 +: 32];
                end
            end
        end
    end

    // Operand lookup with same-cycle writeback bypass.
    always_comb begin
        qry_hit = 1'b0;
        qry_byp = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (bus.wb_valid[p] && bus.wb_entry[p*ROB_BIT +: ROB_BIT] == bus.qry_entry) begin
                qry_hit = 1'b1;
                qry_byp = bus.wb_value[p*32 +: 32];
            end
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)     state <= IDLE;
        else if (rdy_in) state <= state_nx;
    end

    // Pointers, occupancy, busy bits and registered retire/flush outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halted   <= 1'b0;
            cm_valid <= 1'b0;
            cm_rd    <= '0;
            cm_value <= '0;
            cm_entry <= '0;
            fl_pulse <= 1'b0;
            fl_pc    <= '0;
        end else begin
            cm_valid <= 1'b0;
            fl_pulse <= 1'b0;
            if (fire_flush) begin
                busy     <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fl_pulse <= 1'b1;
                fl_pc    <= target[head];
            end else begin
                if (alloc) begin
                    busy[tail] <= 1'b1;
                    tail       <= tail + PTR_ONE;
                end
                if (pop) begin
                    busy[head] <= 1'b0;
                    head       <= head + PTR_ONE;
                end
                case ({alloc, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
                if (fire_reg) begin
                    cm_valid <= 1'b1;
                    cm_rd    <= rd[head];
                    cm_value <= value[head];
                    cm_entry <= head;
                end
                if (fire_halt) halted <= 1'b1;
            end
        end
    end

    // Entry payload: allocation fills the tail, writeback completes busy entries.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !fire_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_hit[i] && busy[i] && !ready[i]) begin
                    ready[i] <= 1'b1;
                    value[i] <= wb_val[i];
                    if (kind[i] == K_BRANCH) begin
                        mispredict[i] <= wb_tk[i] != pred[i];
                        target[i]     <= wb_tgt[i];
                    end
                end
            end
            if (alloc) begin
                ready[tail]      <= bus.issue_done || (bus.issue_kind == K_HALT);
                kind[tail]       <= bus.issue_kind;
                rd[tail]         <= bus.issue_rd;
                value[tail]      <= bus.issue_value;
                pred[tail]       <= bus.issue_pred_taken;
                mispredict[tail] <= 1'b0;
            end
        end
    end

    assign bus.issue_ready  = can_issue;
    assign bus.issue_entry  = tail;
    assign bus.qry_ready    = busy[bus.qry_entry] && (qry_hit || ready[bus.qry_entry]);
    assign bus.qry_value    = qry_hit ? qry_byp : value[bus.qry_entry];
    assign bus.commit_valid = cm_valid;
    assign bus.commit_rd    = cm_rd;
    assign bus.commit_value = cm_value;
    assign bus.commit_entry = cm_entry;
    assign bus.store_commit = (state == ST_WAIT);
    assign bus.flush        = fl_pulse;
    assign bus.flush_pc     = fl_pc;
    assign bus.halt         = halted;
    assign bus.count        = count;
    assign bus.empty        = (count == '0);
endmodule

// File: tb/tb_rob_mp.sv
// Directed bench for rob_mp: fill/drain, bypass, flush, store handshake,
// pointer wrap, halt and asynchronous reset.
module tb_rob_mp;
    localparam int RB = 3;
    localparam int WP = 4;
    localparam int RG = 5;
    localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_HALT = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rob_mp_if #(.ROB_BIT(RB), .WB_PORTS(WP), .REG_BIT(RG)) bus ();

    rob_mp #(.ROB_BIT(RB), .WB_PORTS(WP), .REG_BIT(RG)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        bus.wb_valid  = '0;
        bus.wb_entry  = '0;
        bus.wb_value  = '0;
        bus.wb_taken  = '0;
        bus.wb_target = '0;
    endtask

    task automatic clr_all();
        bus.issue_valid      = 1'b0;
        bus.issue_kind       = K_REG;
        bus.issue_rd         = '0;
        bus.issue_done       = 1'b0;
        bus.issue_value      = '0;
        bus.issue_pred_taken = 1'b0;
        bus.qry_entry        = '0;
        bus.store_ack        = 1'b0;
        clr_wb();
    endtask

    task automatic set_wb(input int p, input logic [RB-1:0] e, input logic [31:0] v,
                          input logic tk, input logic [31:0] tg);
        bus.wb_valid[p]            = 1'b1;
        bus.wb_entry[p*RB +: RB]   = e;
        bus.wb_value[p*32 +: 32]   = v;
        bus.wb_taken[p]            = tk;
        bus.wb_target[p*32 +: 32]  = tg;
    endtask

    task automatic issue(input logic [1:0] k, input int r, input logic done,
                         input logic [31:0] v, input logic pr);
        bus.issue_valid      = 1'b1;
        bus.issue_kind       = k;
        bus.issue_rd         = RG'(r);
        bus.issue_done       = done;
        bus.issue_value      = v;
        bus.issue_pred_taken = pr;
        step();
        bus.issue_valid      = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (bus.empty !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(tag, bus.empty, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int ncm;
        int exp_e[4] = '{6, 7, 0, 1};
        clr_all();

        // reset values while reset is held
        #12;
        check("rst_empty", bus.empty, 1);
        check("rst_iready", bus.issue_ready, 1);
        check("rst_count", bus.count, 0);
        check("rst_cvalid", bus.commit_valid, 0);
        check("rst_stc", bus.store_commit, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_halt", bus.halt, 0);
        check("rst_entry", bus.issue_entry, 0);
        rst_n = 1'b1;
        step();

        // A: fill 8 entries, then complete them on 4 ports over 2 cycles
        for (int i = 0; i < 8; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_kind  = K_REG;
            bus.issue_rd    = RG'(i + 1);
            bus.issue_done  = 1'b0;
            #1;
            check("a_entry", bus.issue_entry, i);
            step();
        end
        bus.issue_valid = 1'b0;
        #1;
        check("a_count", bus.count, 8);
        check("a_full", bus.issue_ready, 0);
        for (int p = 0; p < 4; p++) set_wb(p, RB'(p), 32'h100 + p, 1'b0, 32'h0);
        step();
        clr_wb();
        for (int p = 0; p < 4; p++) set_wb(p, RB'(p + 4), 32'h104 + p, 1'b0, 32'h0);
        step();
        clr_wb();
        for (int i = 0; i < 8; i++) begin
            check("a_cvalid", bus.commit_valid, 1);
            check("a_crd", bus.commit_rd, i + 1);
            check("a_cval", bus.commit_value, 32'h100 + i);
            check("a_cent", bus.commit_entry, i);
            step();
        end
        check("a_done", bus.commit_valid, 0);
        check("a_empty", bus.empty, 1);

        // B: two ports hit entry 2 in one cycle, higher port wins
        issue(K_REG, 9, 1'b0, 32'h0, 1'b0);
        issue(K_REG, 10, 1'b0, 32'h0, 1'b0);
        issue(K_REG, 11, 1'b0, 32'h0, 1'b0);
        bus.qry_entry = 3'd5;
        #1;
        check("b_qry_free", bus.qry_ready, 0);
        set_wb(0, 3'd2, 32'h11, 1'b0, 32'h0);
        set_wb(3, 3'd2, 32'h33, 1'b0, 32'h0);
        bus.qry_entry = 3'd2;
        #1;
        check("b_byp_rdy", bus.qry_ready, 1);
        check("b_byp_val", bus.qry_value, 32'h33);
        step();
        clr_wb();
        #1;
        check("b_st_rdy", bus.qry_ready, 1);
        check("b_st_val", bus.qry_value, 32'h33);
        set_wb(0, 3'd0, 32'hA0, 1'b0, 32'h0);
        set_wb(1, 3'd1, 32'hB0, 1'b0, 32'h0);
        step();
        clr_wb();
        check("b_latency", bus.commit_valid, 0);
        step();
        check("b_c0", bus.commit_value, 32'hA0);
        step();
        check("b_c1", bus.commit_value, 32'hB0);
        step();
        check("b_c2_rd", bus.commit_rd, 11);
        check("b_c2_val", bus.commit_value, 32'h33);

        // C: mispredicted branch flushes three younger entries
        issue(K_BRANCH, 0, 1'b0, 32'h0, 1'b0);
        issue(K_REG, 12, 1'b0, 32'h0, 1'b0);
        issue(K_REG, 13, 1'b0, 32'h0, 1'b0);
        issue(K_REG, 14, 1'b0, 32'h0, 1'b0);
        check("c_count", bus.count, 4);
        set_wb(1, 3'd3, 32'h0, 1'b1, 32'h1000);
        step();
        clr_wb();
        bus.issue_valid = 1'b1;
        bus.issue_kind  = K_REG;
        bus.issue_rd    = 5'd15;
        set_wb(0, 3'd4, 32'h55, 1'b0, 32'h0);
        step();
        bus.issue_valid = 1'b0;
        clr_wb();
        check("c_flush", bus.flush, 1);
        check("c_pc", bus.flush_pc, 32'h1000);
        check("c_count0", bus.count, 0);
        check("c_empty", bus.empty, 1);
        check("c_nocommit", bus.commit_valid, 0);
        #1;
        check("c_tail", bus.issue_entry, 0);
        set_wb(0, 3'd4, 32'h1, 1'b0, 32'h0);
        set_wb(1, 3'd5, 32'h2, 1'b0, 32'h0);
        step();
        clr_wb();
        check("c_pulse", bus.flush, 0);
        ncm = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.commit_valid === 1'b1) ncm++;
            step();
        end
        check("c_younger", ncm, 0);
        check("c_empty2", bus.empty, 1);

        // D: store handshake, ack ignored while frozen
        issue(K_STORE, 0, 1'b0, 32'h0, 1'b0);
        rdy = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_kind  = K_REG;
        bus.issue_rd    = 5'd3;
        step();
        bus.issue_valid = 1'b0;
        rdy = 1'b1;
        check("d_freeze", bus.count, 1);
        set_wb(2, 3'd0, 32'hDEAD, 1'b0, 32'h0);
        step();
        clr_wb();
        check("d_pre", bus.store_commit, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("d_hold", bus.store_commit, 1);
            step();
        end
        rdy = 1'b0;
        bus.store_ack = 1'b1;
        step();
        bus.store_ack = 1'b0;
        rdy = 1'b1;
        check("d_ack_frz", bus.store_commit, 1);
        check("d_cnt_frz", bus.count, 1);
        bus.store_ack = 1'b1;
        step();
        bus.store_ack = 1'b0;
        check("d_drop", bus.store_commit, 0);
        check("d_pop", bus.count, 0);
        check("d_nocv", bus.commit_valid, 0);

        // E: move head to 6, fill to full across the wrap, retire 6,7,0,1
        for (int i = 0; i < 5; i++) issue(K_REG, i + 1, 1'b1, 32'h50 + i, 1'b0);
        drain("e_drain1");
        #1;
        check("e_tail", bus.issue_entry, 6);
        for (int i = 0; i < 8; i++) issue(K_REG, 16 + i, 1'b0, 32'h0, 1'b0);
        check("e_full_cnt", bus.count, 8);
        for (int p = 0; p < 4; p++) set_wb(p, RB'(exp_e[p]), 32'h200 + exp_e[p], 1'b0, 32'h0);
        step();
        clr_wb();
        bus.issue_valid = 1'b1;
        bus.issue_kind  = K_REG;
        bus.issue_rd    = 5'd30;
        #1;
        check("e_noissue", bus.issue_ready, 0);
        step();
        bus.issue_valid = 1'b0;
        check("e_cnt7", bus.count, 7);
        for (int k = 0; k < 4; k++) begin
            check("e_cvalid", bus.commit_valid, 1);
            check("e_centry", bus.commit_entry, exp_e[k]);
            step();
        end
        for (int p = 0; p < 4; p++) set_wb(p, RB'(p + 2), 32'h300 + p, 1'b0, 32'h0);
        step();
        clr_wb();
        drain("e_drain2");

        // F: halt, then asynchronous reset mid-cycle
        issue(K_HALT, 0, 1'b0, 32'h0, 1'b0);
        step();
        check("f_halt", bus.halt, 1);
        check("f_iready", bus.issue_ready, 0);
        issue(K_REG, 7, 1'b1, 32'h77, 1'b0);
        step();
        check("f_nocommit", bus.commit_valid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_r_halt", bus.halt, 0);
        check("f_r_iready", bus.issue_ready, 1);
        check("f_r_empty", bus.empty, 1);
        check("f_r_count", bus.count, 0);
        check("f_r_crd", bus.commit_rd, 0);
        check("f_r_cval", bus.commit_value, 0);
        check("f_r_cent", bus.commit_entry, 0);
        check("f_r_fpc", bus.flush_pc, 0);
        check("f_r_entry", bus.issue_entry, 0);
        rst_n = 1'b1;
        step();
        issue(K_STORE, 0, 1'b0, 32'h0, 1'b0);
        set_wb(0, 3'd0, 32'h9, 1'b0, 32'h0);
        step();
        clr_wb();
        step();
        check("f_st", bus.store_commit, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_rs_stc", bus.store_commit, 0);
        check("f_rs_cnt", bus.count, 0);
        check("f_rs_flush", bus.flush, 0);
        check("f_rs_cv", bus.commit_valid, 0);
        rst_n = 1'b1;
        step();
        step();
        check("f_abandon", bus.store_commit, 0);
        check("f_abandon_e", bus.empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
